ahb2apb_mux: RTL and testbench

//  Single-clock AHB-Lite slave to multi-slave APB4 bridge. Decodes one AHB slot into NUM_SLAVES
//  APB peripherals, each with its own psel, and muxes their prdata/pready/pslverr back.

---
 rtl/ahb2apb_mux.sv | 205 ++++++++++++++++++++
 tb/tb_ahb2apb_mux.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb2apb_mux.sv
// rtl/ahb2apb_mux.sv - AHB-Lite slave to multi-slave APB4 bridge
// Decodes one AHB slot into NUM_SLAVES APB peripherals with timeout and two-cycle ERROR response.
module ahb2apb_mux #(
  parameter int ADDR_BITS  = 32,
  parameter int DATA_BITS  = 32,
  parameter int NUM_SLAVES = 4,
  parameter int SLOT_BITS  = 12,
  parameter int TIMEOUT    = 256
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             ahb_hsel,
  input  logic [1:0]                       ahb_htrans,
  input  logic                             ahb_hready,
  input  logic                             ahb_hwrite,
  input  logic [ADDR_BITS-1:0]             ahb_haddr,
  input  logic [2:0]                       ahb_hsize,
  input  logic [3:0]                       ahb_hprot,
  input  logic [DATA_BITS-1:0]             ahb_hwdata,
  output logic [DATA_BITS-1:0]             ahb_hrdata,
  output logic                             ahb_hreadyout,
  output logic                             ahb_hresp,
  output logic [NUM_SLAVES-1:0]            apb_psel,
  output logic                             apb_penable,
  output logic                             apb_pwrite,
  output logic [ADDR_BITS-1:0]             apb_paddr,
  output logic [DATA_BITS-1:0]             apb_pwdata,
  output logic [DATA_BITS/8-1:0]           apb_pstrb,
  output logic [2:0]                       apb_pprot,
  input  logic [NUM_SLAVES-1:0]            apb_pready,
  input  logic [NUM_SLAVES-1:0]            apb_pslverr,
  input  logic [NUM_SLAVES*DATA_BITS-1:0]  apb_prdata
);

  localparam int STRB     = DATA_BITS / 8;
  localparam int ALIGN    = $clog2(STRB);
  localparam int DEC_BITS = 4;
  localparam int CNT_BITS = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [DEC_BITS:0]   NUM_SL   = (DEC_BITS+1)'(NUM_SLAVES);
  localparam logic [2:0]          ALIGN_W  = 3'(ALIGN);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(TIMEOUT - 1);
  localparam logic [2*STRB-1:0]   ONE_W    = (2*STRB)'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_SETUP, S_ACCESS, S_ERR1, S_ERR2
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic                   write_q, write_d;
  logic [2:0]             size_q, size_d;
  logic [1:0]             prot_q, prot_d;
  logic [CNT_BITS-1:0]    cnt_q, cnt_d;
  logic [NUM_SLAVES-1:0]  psel_q, psel_d;
  logic                   penable_q, penable_d;
  logic                   pwrite_q, pwrite_d;
  logic [ADDR_BITS-1:0]   paddr_q, paddr_d;
  logic [DATA_BITS-1:0]   pwdata_q, pwdata_d;
  logic [STRB-1:0]        pstrb_q, pstrb_d;
  logic [2:0]             pprot_q, pprot_d;
  logic [DATA_BITS-1:0]   hrdata_q, hrdata_d;

  logic                   accept;
  logic [DEC_BITS-1:0]    slot;
  logic                   dec_err;
  logic [NUM_SLAVES-1:0]  sel_dec;
  logic [2*STRB-1:0]      strb_wide;
  logic                   pready_sel;
  logic                   pslverr_sel;
  logic [DATA_BITS-1:0]   prdata_sel;
  logic                   unused_bits;

  assign unused_bits = ^{ahb_htrans[0], ahb_hprot[3:2]};

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    size_d    = size_q;
    prot_d    = prot_q;
    cnt_d     = cnt_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    pprot_d   = pprot_q;
    hrdata_d  = hrdata_q;

    accept = ahb_hsel & ahb_htrans[1] & ahb_hready;
    // A full 4-bit slot field is decoded so windows above NUM_SLAVES never alias onto a real slave.
    slot    = addr_q[SLOT_BITS +: DEC_BITS];
    dec_err = ({1'b0, slot} >= NUM_SL) || (size_q > ALIGN_W);
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel_dec[i] = (slot == DEC_BITS'(i));
    end
    strb_wide = ((ONE_W << (8'd1 << size_q)) - ONE_W) << addr_q[ALIGN-1:0];

    pready_sel  = |(apb_pready & psel_q);
    pslverr_sel = |(apb_pslverr & psel_q);
    prdata_sel  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (psel_q[i]) prdata_sel = prdata_sel | apb_prdata[i*DATA_BITS +: DATA_BITS];
    end

    case (state_q)
      S_IDLE, S_ERR2: begin
        state_d = S_IDLE;
        if (accept) begin
          addr_d  = ahb_haddr;
          write_d = ahb_hwrite;
          size_d  = ahb_hsize;
          prot_d  = ahb_hprot[1:0];
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        pwdata_d = ahb_hwdata;
        if (dec_err) begin
          state_d = S_ERR1;
        end else begin
          psel_d   = sel_dec;
          pwrite_d = write_q;
          paddr_d  = {addr_q[ADDR_BITS-1:ALIGN], {ALIGN{1'b0}}};
          pprot_d  = {~prot_q[0], 1'b0, prot_q[1]};
          pstrb_d  = write_q ? strb_wide[STRB-1:0] : '0;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        if (pready_sel) begin
          psel_d    = '0;
          penable_d = 1'b0;
          if (pslverr_sel) begin
            state_d = S_ERR1;
          end else begin
            if (!pwrite_q) hrdata_d = prdata_sel;
            state_d = S_IDLE;
          end
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          psel_d    = '0;
          penable_d = 1'b0;
          state_d   = S_ERR1;
        end else begin
          cnt_d = cnt_q + CNT_BITS'(1);
        end
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      size_q    <= '0;
      prot_q    <= '0;
      cnt_q     <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      pprot_q   <= '0;
      hrdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      size_q    <= size_d;
      prot_q    <= prot_d;
      cnt_q     <= cnt_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      pprot_q   <= pprot_d;
      hrdata_q  <= hrdata_d;
    end
  end

  assign ahb_hreadyout = (state_q == S_IDLE) || (state_q == S_ERR2);
  assign ahb_hresp     = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign ahb_hrdata    = hrdata_q;
  assign apb_psel      = psel_q;
  assign apb_penable   = penable_q;
  assign apb_pwrite    = pwrite_q;
  assign apb_paddr     = paddr_q;
  assign apb_pwdata    = pwdata_q;
  assign apb_pstrb     = pstrb_q;
  assign apb_pprot     = pprot_q;

endmodule

// File: tb/tb_ahb2apb_mux.sv
// tb/tb_ahb2apb_mux.sv - directed self-checking bench for ahb2apb_mux
// Four slaves, 32-bit data, TIMEOUT=8; outputs sampled on the falling edge.
module tb_ahb2apb_mux;

  logic         clock = 1'b0;
  logic         reset;
  logic         ahb_hsel;
  logic [1:0]   ahb_htrans;
  logic         ahb_hready;
  logic         ahb_hwrite;
  logic [31:0]  ahb_haddr;
  logic [2:0]   ahb_hsize;
  logic [3:0]   ahb_hprot;
  logic [31:0]  ahb_hwdata;
  logic [31:0]  ahb_hrdata;
  logic         ahb_hreadyout;
  logic         ahb_hresp;
  logic [3:0]   apb_psel;
  logic         apb_penable;
  logic         apb_pwrite;
  logic [31:0]  apb_paddr;
  logic [31:0]  apb_pwdata;
  logic [3:0]   apb_pstrb;
  logic [2:0]   apb_pprot;
  logic [3:0]   apb_pready;
  logic [3:0]   apb_pslverr;
  logic [127:0] apb_prdata;

  int n_cmp  = 0;
  int n_fail = 0;

  int          rdy_lo, sel_hi, en_hi, resp_hi;
  logic [1:0]  resp_rdy;
  logic [3:0]  sel_seen;
  logic [31:0] cap_paddr, cap_pwdata;
  logic [3:0]  cap_pstrb;
  logic        cap_pwrite;
  logic [2:0]  cap_pprot;
  logic        done;

  ahb2apb_mux #(
    .ADDR_BITS(32), .DATA_BITS(32), .NUM_SLAVES(4), .SLOT_BITS(12), .TIMEOUT(8)
  ) dut (
    .clock(clock), .reset(reset),
    .ahb_hsel(ahb_hsel), .ahb_htrans(ahb_htrans), .ahb_hready(ahb_hready),
    .ahb_hwrite(ahb_hwrite), .ahb_haddr(ahb_haddr), .ahb_hsize(ahb_hsize),
    .ahb_hprot(ahb_hprot), .ahb_hwdata(ahb_hwdata), .ahb_hrdata(ahb_hrdata),
    .ahb_hreadyout(ahb_hreadyout), .ahb_hresp(ahb_hresp),
    .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_pwrite(apb_pwrite),
    .apb_paddr(apb_paddr), .apb_pwdata(apb_pwdata), .apb_pstrb(apb_pstrb),
    .apb_pprot(apb_pprot), .apb_pready(apb_pready), .apb_pslverr(apb_pslverr),
    .apb_prdata(apb_prdata)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic addr_phase(input logic wr, input logic [31:0] addr, input logic [2:0] size);
    ahb_hsel   = 1'b1;
    ahb_htrans = 2'b10;
    ahb_hready = 1'b1;
    ahb_hwrite = wr;
    ahb_haddr  = addr;
    ahb_hsize  = size;
    ahb_hprot  = 4'b0011;
    tick();
    ahb_hsel   = 1'b0;
    ahb_htrans = 2'b00;
  endtask

  // Runs one transfer from the address phase until the bridge is back in plain IDLE.
  // The selected slave holds pready low for its first 'stall' ACCESS cycles; other slaves show pready=1.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, input int stall, input logic slverr);
    int k;
    addr_phase(wr, addr, size);
    ahb_hwdata = wdata;
    rdy_lo = 0; sel_hi = 0; en_hi = 0; resp_hi = 0; resp_rdy = 2'b00; sel_seen = 4'h0;
    k = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (ahb_hreadyout && !ahb_hresp) begin
        done = 1'b1;
      end else begin
        if (!ahb_hreadyout) rdy_lo++;
        if (ahb_hresp) begin
          resp_hi++;
          resp_rdy = {resp_rdy[0], ahb_hreadyout};
        end
        if (apb_psel != 4'h0) sel_hi++;
        sel_seen = sel_seen | apb_psel;
        if (apb_psel != 4'h0 && !apb_penable) begin
          cap_paddr  = apb_paddr;
          cap_pwdata = apb_pwdata;
          cap_pstrb  = apb_pstrb;
          cap_pwrite = apb_pwrite;
          cap_pprot  = apb_pprot;
        end
        if (apb_penable) begin
          en_hi++;
          k++;
        end
        apb_pready  = (apb_penable && k <= stall) ? ~apb_psel : 4'hF;
        apb_pslverr = slverr ? 4'hF : 4'h0;
        tick();
      end
    end
    apb_pready  = 4'hF;
    apb_pslverr = 4'h0;
    check("xfer_bound", done, 1'b1);
  endtask

  initial begin
    reset       = 1'b1;
    ahb_hsel    = 1'b0;
    ahb_htrans  = 2'b00;
    ahb_hready  = 1'b1;
    ahb_hwrite  = 1'b0;
    ahb_haddr   = 32'h0;
    ahb_hsize   = 3'd2;
    ahb_hprot   = 4'b0011;
    ahb_hwdata  = 32'h0;
    apb_pready  = 4'hF;
    apb_pslverr = 4'h0;
    apb_prdata  = {32'h5A5A5A5A, 32'h22222222, 32'hCAFEF00D, 32'h12345678};
    @(negedge clock);
    tick();
    tick();
    reset = 1'b0;

    check("rst_hreadyout", ahb_hreadyout, 1'b1);
    check("rst_hresp",     ahb_hresp,     1'b0);
    check("rst_psel",      apb_psel,      4'h0);
    check("rst_penable",   apb_penable,   1'b0);
    check("rst_hrdata",    ahb_hrdata,    32'h0);
    check("rst_pstrb",     apb_pstrb,     4'h0);

    // Idle/busy htrans with hsel does nothing
    ahb_hsel = 1'b1; ahb_htrans = 2'b01;
    tick();
    check("busy_hreadyout", ahb_hreadyout, 1'b1);
    check("busy_psel",      apb_psel,      4'h0);
    ahb_hsel = 1'b0; ahb_htrans = 2'b00;

    // 1. Read slot 1, zero wait
    xfer(1'b0, 32'h0000_1004, 3'd2, 32'h0, 0, 1'b0);
    check("rd1_hrdata",  ahb_hrdata, 32'hCAFEF00D);
    check("rd1_rdy_lo",  rdy_lo,     3);
    check("rd1_sel_hi",  sel_hi,     2);
    check("rd1_sel",     sel_seen,   4'b0010);
    check("rd1_paddr",   cap_paddr,  32'h0000_1004);
    check("rd1_pstrb",   cap_pstrb,  4'b0000);
    check("rd1_pwrite",  cap_pwrite, 1'b0);
    check("rd1_pprot",   cap_pprot,  3'b001);
    check("rd1_resp",    resp_hi,    0);

    // 2. Byte write, back-to-back
    xfer(1'b1, 32'h0000_2003, 3'd0, 32'hAB000000, 0, 1'b0);
    check("wb_sel",    sel_seen,   4'b0100);
    check("wb_paddr",  cap_paddr,  32'h0000_2000);
    check("wb_pstrb",  cap_pstrb,  4'b1000);
    check("wb_pwdata", cap_pwdata, 32'hAB000000);
    check("wb_pwrite", cap_pwrite, 1'b1);
    check("wb_rdy_lo", rdy_lo,     3);
    check("wb_hrdata", ahb_hrdata, 32'hCAFEF00D);

    xfer(1'b1, 32'h0000_1002, 3'd1, 32'h5678_0000, 0, 1'b0);
    check("wh_pstrb", cap_pstrb, 4'b1100);
    check("wh_paddr", cap_paddr, 32'h0000_1000);
    xfer(1'b1, 32'h0000_0000, 3'd2, 32'h0BAD_F00D, 0, 1'b0);
    check("ww_pstrb", cap_pstrb, 4'b1111);
    check("ww_sel",   sel_seen,  4'b0001);

    // 3. Slave 3 stalls 5 cycles
    xfer(1'b0, 32'h0000_3010, 3'd2, 32'h0, 5, 1'b0);
    check("st_en_hi",  en_hi,      6);
    check("st_rdy_lo", rdy_lo,     8);
    check("st_resp",   resp_hi,    0);
    check("st_hrdata", ahb_hrdata, 32'h5A5A5A5A);

    // 4. Slave error, then unmapped slot 5, then oversize
    xfer(1'b0, 32'h0000_0004, 3'd2, 32'h0, 0, 1'b1);
    check("se_resp",     resp_hi,    2);
    check("se_resp_rdy", resp_rdy,   2'b01);
    check("se_hrdata",   ahb_hrdata, 32'h5A5A5A5A);
    xfer(1'b0, 32'h0000_5000, 3'd2, 32'h0, 0, 1'b0);
    check("um_resp",     resp_hi,  2);
    check("um_resp_rdy", resp_rdy, 2'b01);
    check("um_sel",      sel_seen, 4'h0);
    check("um_rdy_lo",   rdy_lo,   2);
    xfer(1'b1, 32'h0000_1000, 3'd3, 32'h0, 0, 1'b0);
    check("os_resp", resp_hi,  2);
    check("os_sel",  sel_seen, 4'h0);

    // 5. Timeout after 8 ACCESS cycles
    xfer(1'b0, 32'h0000_2000, 3'd2, 32'h0, 100, 1'b0);
    check("to_en_hi",    en_hi,      8);
    check("to_sel_hi",   sel_hi,     9);
    check("to_resp",     resp_hi,    2);
    check("to_resp_rdy", resp_rdy,   2'b01);
    check("to_rdy_lo",   rdy_lo,     11);
    check("to_hrdata",   ahb_hrdata, 32'h5A5A5A5A);

    // 6. Reset mid-ACCESS
    addr_phase(1'b0, 32'h0000_3000, 3'd2);
    apb_pready = 4'h0;
    tick();
    tick();
    check("ra_penable", apb_penable, 1'b1);
    check("ra_psel",    apb_psel,    4'b1000);
    reset = 1'b1;
    tick();
    check("ra_psel_rst",    apb_psel,      4'h0);
    check("ra_penable_rst", apb_penable,   1'b0);
    check("ra_hready_rst",  ahb_hreadyout, 1'b1);
    check("ra_hresp_rst",   ahb_hresp,     1'b0);
    reset = 1'b0;
    apb_pready = 4'hF;
    xfer(1'b0, 32'h0000_0008, 3'd2, 32'h0, 0, 1'b0);
    check("ra_hrdata", ahb_hrdata, 32'h12345678);
    check("ra_rdy_lo", rdy_lo,     3);
    check("ra_resp",   resp_hi,    0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
